// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned PORT_CORE  = 0;
    localparam int unsigned PORT_DBG   = 1;
    localparam int unsigned NUM_PORTS  = 2;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // Response word width; the arbiter's DATA_W is expected to match it.
    localparam int unsigned RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    // Which port wins when both are eligible.
    typedef enum logic {
        PTR_CORE = 1'b0,
        PTR_DBG  = 1'b1
    } ptr_e;

    function automatic logic is_misaligned(input logic [1:0] low_addr);
        return |(low_addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; owns the priority pointer, grant is combinational.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    ptr_e ptr_q, ptr_d;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_q == PTR_DBG) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        // Priority passes to the port that lost this cycle; idle cycles hold it.
        if (grant[PORT_CORE]) begin
            ptr_d = PTR_DBG;
        end else if (grant[PORT_DBG]) begin
            ptr_d = PTR_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_CORE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory, with
// registered back-pressurable responses and misaligned-access flagging.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_req_valid,
    output logic                   m0_req_ready,
    input  logic                   m0_req_we,
    input  logic [ADDR_W-1:0]      m0_req_addr,
    input  logic [DATA_W-1:0]      m0_req_wdata,
    output logic                   m0_rsp_valid,
    input  logic                   m0_rsp_ready,
    output logic [DATA_W-1:0]      m0_rsp_rdata,
    output logic                   m0_rsp_err,

    input  logic                   m1_req_valid,
    output logic                   m1_req_ready,
    input  logic                   m1_req_we,
    input  logic [ADDR_W-1:0]      m1_req_addr,
    input  logic [DATA_W-1:0]      m1_req_wdata,
    output logic                   m1_rsp_valid,
    input  logic                   m1_rsp_ready,
    output logic [DATA_W-1:0]      m1_rsp_rdata,
    output logic                   m1_rsp_err,

    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_write_data,
    input  logic [DATA_W-1:0]      mem_read_data,

    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] rsp_ready;
    logic [NUM_PORTS-1:0] slot_free;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] grant;

    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    rsp_t                 rsp_q [NUM_PORTS];
    rsp_t                 rsp_d [NUM_PORTS];

    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic sel_we;
    logic misaligned;

    assign req_valid = {m1_req_valid, m0_req_valid};
    assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};

    // A held response blocks its own port only; draining frees the slot same cycle.
    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign elig      = req_valid & slot_free & {NUM_PORTS{~rst}};

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig),
        .grant (grant)
    );

    assign m0_req_ready = grant[PORT_CORE];
    assign m1_req_ready = grant[PORT_DBG];

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        sel_we         = 1'b0;
        if (grant[PORT_CORE]) begin
            mem_addr       = m0_req_addr;
            mem_write_data = m0_req_wdata;
            sel_we         = m0_req_we;
        end else if (grant[PORT_DBG]) begin
            mem_addr       = m1_req_addr;
            mem_write_data = m1_req_wdata;
            sel_we         = m1_req_we;
        end
        misaligned = is_misaligned(mem_addr[1:0]);
        mem_wr_en  = (|grant) && sel_we && !misaligned;
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rsp_valid_d[p] = rsp_valid_q[p];
            rsp_d[p]       = rsp_q[p];
            if (grant[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_d[p].err   = misaligned;
                rsp_d[p].rdata = (!misaligned && !sel_we) ? mem_read_data : '0;
            end else if (rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (m0_req_valid && !grant[PORT_CORE] && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            stall_q     <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rsp_q[p] <= '0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            stall_q     <= stall_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rsp_q[p] <= rsp_d[p];
            end
        end
    end

    assign m0_rsp_valid = rsp_valid_q[PORT_CORE];
    assign m0_rsp_rdata = rsp_q[PORT_CORE].rdata;
    assign m0_rsp_err   = rsp_q[PORT_CORE].err;
    assign m1_rsp_valid = rsp_valid_q[PORT_DBG];
    assign m1_rsp_rdata = rsp_q[PORT_DBG].rdata;
    assign m1_rsp_err   = rsp_q[PORT_DBG].err;
    assign stall_cnt    = stall_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port, word-addressed data memory.
- Port 0 is the core load/store unit. Port 1 is the debug/loader master.
- Grants at most one memory access per cycle using round-robin, with valid/ready request handshakes.
- Returns a registered, back-pressurable response per port and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- STALL_CNT_W, 16, width of the saturating stall counter for port 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req_valid  in  1  port 0 request valid.
- m0_req_ready  out  1  port 0 request accepted this cycle.
- m0_req_we  in  1  port 0: 1 = store, 0 = load.
- m0_req_addr  in  ADDR_W  port 0 byte address.
- m0_req_wdata  in  DATA_W  port 0 store data.
- m0_rsp_valid  out  1  port 0 response valid.
- m0_rsp_ready  in  1  port 0 response consumed.
- m0_rsp_rdata  out  DATA_W  port 0 load data (0 for stores/errors).
- m0_rsp_err  out  1  port 0 misaligned-access flag.
- m1_* (req_valid, req_ready, req_we, req_addr, req_wdata, rsp_valid, rsp_ready, rsp_rdata, rsp_err): identical to m0_* for port 1.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address; memory indexes addr[ADDR_W-1:2].
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  memory combinational read data.
- stall_cnt  out  STALL_CNT_W  cycles where m0_req_valid=1 and m0_req_ready=0, saturating.

Behaviour:
- Reset (rst=1 at posedge):
  - mX_rsp_valid=0, mX_rsp_rdata=0, mX_rsp_err=0, stall_cnt=0, priority pointer=port 0.
  - Pending responses are discarded, including on reset mid-transaction.
  - While rst=1: mX_req_ready=0 and mem_wr_en=0.
- Slot free: slot_free_X = !mX_rsp_valid || mX_rsp_ready. This allows accept-and-drain in the same cycle.
- Eligibility: elig_X = mX_req_valid && slot_free_X && !rst.
- Grant (combinational):
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port named by the pointer.
  - mX_req_ready = grant_X.
- Pointer: after any accepted request, the pointer moves to the non-granted port. With no grant it holds.
- Memory drive (combinational):
  - mem_addr and mem_write_data come from the granted port.
  - mem_wr_en = grant && we && (addr[1:0]==0).
  - With no grant: mem_addr=0, mem_write_data=0, mem_wr_en=0.
- Misaligned access (addr[1:0]!=0): no memory write. The response has err=1 and rdata=0.
- Response timing: registered, latency 1.
  - At the accept posedge, mX_rsp_valid<=1.
  - rdata<=mem_read_data for an aligned load, 0 otherwise.
  - err is set as above.
- Response hold: the response stays stable while rsp_valid=1 and rsp_ready=0. If rsp_ready=1 and no new accept, rsp_valid<=0.
- Ordering: a store accepted in cycle N is visible to any load accepted in cycle N+1 or later, from either port.
- Simultaneous events: both ports request the same address in the same cycle → only the granted port accesses; the other waits and sees post-write data.
- Backpressure:
  - A port whose response is held gets no grant.
  - The other port is unaffected, and the pointer does not advance for the blocked port.
- stall_cnt: increments when m0_req_valid && !m0_req_ready and saturates at all-ones.

Decomposition:
- Package dmem_arb_pkg:
  - PORT_CORE=0, PORT_DBG=1.
  - NUM_PORTS=2.
  - ALIGN_MASK=2'b11.
  - Response struct typedef {rdata, err}.
- Sub-module rr_arbiter2: 2-way round-robin picker.
  - Inputs: clk, rst, elig[1:0]. Outputs: grant[1:0].
  - Owns the pointer register; combinational grant.

Test Plan (memory preloaded so word k = k):
- Single load: m0 load addr 0x10, rsp_ready=1 → m0_req_ready=1 same cycle; next cycle m0_rsp_valid=1, rdata=4, err=0.
- Contention after reset: both ports load (m0 0x8, m1 0xC) every cycle → grants alternate m0, m1, m0…; rdata m0=2, m1=3; m1 waits exactly 1 cycle.
- Store then load: m1 store 0x20 data 0xDEADBEEF; next cycle m0 load 0x20 → rdata=0xDEADBEEF. The store response has rdata=0.
- Misaligned: m0 store addr 0x22 data 0x55 → mem_wr_en=0, rsp_err=1; a later load 0x20 returns the prior value.
- Backpressure: m0_rsp_ready=0 with two m0 loads queued → second m0_req_ready=0, stall_cnt increments each cycle, m1 traffic still granted; raise rsp_ready → second load accepted that cycle.
- Reset mid-op: assert rst while m1_rsp_valid=1 and m0 requesting → next cycle all rsp_valid=0, stall_cnt=0; first grant after reset under contention goes to m0.
